display_spi_rx: RTL and testbench

DISPLAY_SPI_RX -- requirements
Module: display_spi_rx

---
 rtl/display_spi_rx_pkg.sv | 39 +++
 rtl/display_spi_rx_bus_sync.sv | 39 +++
 rtl/display_spi_rx.sv | 162 ++++++++++++++++
 tb/tb_display_spi_rx.sv | 375 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/display_spi_rx_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : display_spi_rx_pkg
//  Description : Shared types and constants for the display SPI receiver:
//                FSM state encoding, framebuffer geometry, command opcodes.
//  Revision    : 1.0 - initial release
// ============================================================================
package display_spi_rx_pkg;

    // Receiver FSM states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,   // cs high, waiting for a transfer
        ST_SHIFT = 2'd1,   // cs low, collecting bits 0..6
        ST_DONE  = 2'd2    // 8th bit received, strobe cycle
    } state_t;

    // Framebuffer geometry
    localparam int COLS  = 128;
    localparam int PAGES = 8;

    // Command opcode bases
    localparam logic [7:0] PAGE_SET = 8'hB0;   // 0xB0..0xB7 : page = cmd[2:0]
    localparam logic [7:0] COL_LO   = 8'h00;   // 0x00..0x0F : col[3:0] = cmd[3:0]
    localparam logic [7:0] COL_HI   = 8'h10;   // 0x10..0x17 : col[6:4] = cmd[2:0]

    function automatic logic is_page_set(input logic [7:0] b);
        return b[7:3] == PAGE_SET[7:3];
    endfunction

    function automatic logic is_col_lo(input logic [7:0] b);
        return b[7:4] == COL_LO[7:4];
    endfunction

    function automatic logic is_col_hi(input logic [7:0] b);
        return b[7:3] == COL_HI[7:3];
    endfunction

endpackage
`default_nettype wire

// File: rtl/display_spi_rx_bus_sync.sv
`default_nettype none
// ============================================================================
//  Module      : display_spi_rx_bus_sync
//  Description : STAGES-deep flip-flop synchronizer for one asynchronous
//                serial bus input, resetting to the line's idle level.
//  Revision    : 1.0 - initial release
// ============================================================================
module display_spi_rx_bus_sync #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] r_chain;

    generate
        if (STAGES == 1) begin : g_single
            // Single-flop capture
            always_ff @(posedge clk) begin
                if (rst) r_chain <= RESET_VAL;
                else     r_chain <= d;
            end
        end else begin : g_multi
            // Shift the input down the chain, oldest sample at the top
            always_ff @(posedge clk) begin
                if (rst) r_chain <= {STAGES{RESET_VAL}};
                else     r_chain <= {r_chain[STAGES-2:0], d};
            end
        end
    endgenerate

    assign q = r_chain[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/display_spi_rx.sv
`default_nettype none
// ============================================================================
//  Module      : display_spi_rx
//  Description : Receives the serial display bus (sclk/sdin/cs/dc/reset) of
//                a page-addressed monochrome panel and turns it into
//                framebuffer writes and command strobes.
//  Revision    : 1.0 - initial release
// ============================================================================
module display_spi_rx
    import display_spi_rx_pkg::*;
#(
    parameter int FB_BYTES    = 1024,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        io_sclk,
    input  logic        io_sdin,
    input  logic        io_cs,
    input  logic        io_dc,
    input  logic        io_reset,
    output logic        fb_we,
    output logic [9:0]  fb_addr,
    output logic [7:0]  fb_data,
    output logic        cmd_valid,
    output logic [7:0]  cmd_byte,
    output logic        frame_done,
    output logic        frame_err
);

    localparam int          c_col_w     = $clog2(COLS);
    localparam int          c_page_w    = $clog2(PAGES);
    localparam logic [9:0]  c_last_addr = 10'(FB_BYTES - 1);

    logic w_sclk_s, w_sdin_s, w_cs_s, w_dc_s, w_rstn_s;

    display_spi_rx_bus_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
        .clk(clk), .rst(rst), .d(io_sclk), .q(w_sclk_s));
    display_spi_rx_bus_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sdin (
        .clk(clk), .rst(rst), .d(io_sdin), .q(w_sdin_s));
    display_spi_rx_bus_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
        .clk(clk), .rst(rst), .d(io_cs), .q(w_cs_s));
    display_spi_rx_bus_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_dc (
        .clk(clk), .rst(rst), .d(io_dc), .q(w_dc_s));
    display_spi_rx_bus_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_rst (
        .clk(clk), .rst(rst), .d(io_reset), .q(w_rstn_s));

    logic                r_sclk_prev;
    logic                r_cs_prev;
    state_t              r_state;
    logic [2:0]          r_bit_cnt;
    logic [6:0]          r_shift;
    logic [c_page_w-1:0] r_page;
    logic [c_col_w-1:0]  r_col;

    logic       w_sclk_rise;
    logic       w_cs_fall;
    logic [7:0] w_byte;
    logic [9:0] w_addr;
    logic [9:0] w_addr_next;

    assign w_sclk_rise = w_sclk_s & ~r_sclk_prev;
    assign w_cs_fall   = ~w_cs_s & r_cs_prev;
    // Byte as it stands once the bit sampled this cycle is shifted in
    assign w_byte      = {r_shift, w_sdin_s};
    assign w_addr      = {r_page, r_col};
    assign w_addr_next = w_addr + 10'd1;

    // Previous synchronized levels for edge detection
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sclk_prev <= 1'b0;
            r_cs_prev   <= 1'b1;
        end else begin
            r_sclk_prev <= w_sclk_s;
            r_cs_prev   <= w_cs_s;
        end
    end

    // Receiver FSM: bit shifting, byte dispatch, address tracking, strobes
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_bit_cnt  <= 3'd0;
            r_shift    <= 7'd0;
            r_page     <= '0;
            r_col      <= '0;
            fb_we      <= 1'b0;
            fb_addr    <= 10'd0;
            fb_data    <= 8'd0;
            cmd_valid  <= 1'b0;
            cmd_byte   <= 8'd0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            fb_we      <= 1'b0;
            cmd_valid  <= 1'b0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;

            if (!w_rstn_s) begin
                // Panel reset line overrides everything on the bus
                r_state   <= ST_IDLE;
                r_bit_cnt <= 3'd0;
                r_page    <= '0;
                r_col     <= '0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (w_cs_fall) begin
                            r_state   <= ST_SHIFT;
                            r_bit_cnt <= 3'd0;
                        end
                    end

                    ST_SHIFT: begin
                        if (w_sclk_rise && (r_bit_cnt == 3'd7)) begin
                            // 8th bit completes the byte even if cs rises now
                            r_state   <= ST_DONE;
                            r_bit_cnt <= 3'd0;
                            if (w_dc_s) begin
                                fb_we      <= 1'b1;
                                fb_data    <= w_byte;
                                fb_addr    <= w_addr;
                                frame_done <= (w_addr == c_last_addr);
                                {r_page, r_col} <= w_addr_next;
                            end else begin
                                cmd_valid <= 1'b1;
                                cmd_byte  <= w_byte;
                                if (is_page_set(w_byte)) begin
                                    r_page <= w_byte[2:0];
                                end else if (is_col_lo(w_byte)) begin
                                    r_col[3:0] <= w_byte[3:0];
                                end else if (is_col_hi(w_byte)) begin
                                    r_col[6:4] <= w_byte[2:0];
                                end
                            end
                        end else if (w_cs_s) begin
                            // Deselect mid-byte: drop the partial byte
                            r_state   <= ST_IDLE;
                            r_bit_cnt <= 3'd0;
                            frame_err <= (r_bit_cnt != 3'd0) || w_sclk_rise;
                        end else if (w_sclk_rise) begin
                            r_shift   <= w_byte[6:0];
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                        end
                    end

                    ST_DONE: begin
                        r_state <= w_cs_s ? ST_IDLE : ST_SHIFT;
                    end

                    default: begin
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_display_spi_rx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_display_spi_rx
//  Description : Directed self-checking bench for display_spi_rx.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_display_spi_rx;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       io_sclk = 1'b0;
    logic       io_sdin = 1'b0;
    logic       io_cs = 1'b1;
    logic       io_dc = 1'b0;
    logic       io_reset = 1'b1;
    logic       fb_we;
    logic [9:0] fb_addr;
    logic [7:0] fb_data;
    logic       cmd_valid;
    logic [7:0] cmd_byte;
    logic       frame_done;
    logic       frame_err;

    display_spi_rx #(.FB_BYTES(1024), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst),
        .io_sclk(io_sclk), .io_sdin(io_sdin), .io_cs(io_cs),
        .io_dc(io_dc), .io_reset(io_reset),
        .fb_we(fb_we), .fb_addr(fb_addr), .fb_data(fb_data),
        .cmd_valid(cmd_valid), .cmd_byte(cmd_byte),
        .frame_done(frame_done), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int npass  = 0;
    int ntotal = 0;

    // Event capture, sampled on the falling edge
    logic [18:0] wr_q[$];      // {frame_done, addr, data}
    logic [7:0]  cmd_q[$];
    int err_cycles      = 0;
    int orphan_done     = 0;
    int last_strobe_cyc = 0;
    int last_rise_cyc   = 0;

    always @(negedge clk) begin
        if (fb_we) begin
            wr_q.push_back({frame_done, fb_addr, fb_data});
            last_strobe_cyc = cyc;
        end
        if (cmd_valid) begin
            cmd_q.push_back(cmd_byte);
            last_strobe_cyc = cyc;
        end
        if (frame_err) err_cycles++;
        if (frame_done && !fb_we) orphan_done++;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_capture();
        wr_q.delete();
        cmd_q.delete();
        err_cycles  = 0;
        orphan_done = 0;
    endtask

    task automatic cs_begin();
        io_sclk = 1'b0;
        tick(2);
        io_cs = 1'b0;
        tick(4);
    endtask

    task automatic cs_end();
        tick(4);
        io_cs   = 1'b1;
        io_sclk = 1'b0;
        tick(6);
    endtask

    // Shift out the top nbits of b MSB-first; optionally raise cs with the last rise
    task automatic send_bits(input logic [7:0] b, input int nbits, input logic dc,
                             input int half, input bit cs_with_last);
        io_dc = dc;
        for (int i = 7; i > 7 - nbits; i--) begin
            io_sclk = 1'b0;
            io_sdin = b[i];
            tick(half);
            io_sclk = 1'b1;
            if (cs_with_last && (i == 8 - nbits)) io_cs = 1'b1;
            last_rise_cyc = cyc;
            tick(half);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic dc, input int half);
        send_bits(b, 8, dc, half, 1'b0);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(3);
        ntotal++;
        if ({fb_we, cmd_valid, frame_done, frame_err} !== 4'b0000)
            $display("FAIL reset_strobes: got %b want 0000", {fb_we, cmd_valid, frame_done, frame_err});
        else npass++;
        ntotal++;
        if ({fb_addr, fb_data} !== 18'd0)
            $display("FAIL reset_fb: got addr %0d data %h want 0/00", fb_addr, fb_data);
        else npass++;
        ntotal++;
        if (cmd_byte !== 8'h00)
            $display("FAIL reset_cmd_byte: got %h want 00", cmd_byte);
        else npass++;
        rst = 1'b0;
        tick(4);
    endtask

    task automatic test_cmd_then_data();
        int lat;
        clear_capture();
        cs_begin();
        send_byte(8'hB3, 1'b0, 3);
        tick(2);
        lat = last_strobe_cyc - last_rise_cyc;
        send_byte(8'hA5, 1'b1, 3);
        tick(2);
        cs_end();
        ntotal++;
        if (lat !== 3) $display("FAIL strobe_latency: got %0d want 3", lat);
        else npass++;
        ntotal++;
        if (cmd_q.size() !== 1 || cmd_q[0] !== 8'hB3)
            $display("FAIL page_cmd: got n=%0d byte %h want n=1 byte b3", cmd_q.size(),
                     cmd_q.size() > 0 ? cmd_q[0] : 8'h00);
        else npass++;
        ntotal++;
        if (wr_q.size() !== 1) $display("FAIL page_data_count: got %0d want 1", wr_q.size());
        else npass++;
        if (wr_q.size() > 0) begin
            ntotal++;
            if (wr_q[0] !== {1'b0, 10'd384, 8'hA5})
                $display("FAIL page_data: got done %b addr %0d data %h want 0 384 a5",
                         wr_q[0][18], wr_q[0][17:8], wr_q[0][7:0]);
            else npass++;
        end
    endtask

    task automatic test_addr_cmds();
        clear_capture();
        cs_begin();
        send_byte(8'hB0, 1'b0, 3);
        send_byte(8'h05, 1'b0, 3);
        send_byte(8'hAF, 1'b0, 3);   // not an address command
        send_byte(8'h12, 1'b0, 3);
        send_byte(8'h3C, 1'b1, 3);
        tick(2);
        cs_end();
        ntotal++;
        if (cmd_q.size() !== 4 || cmd_q[2] !== 8'hAF)
            $display("FAIL other_cmd: got n=%0d third %h want n=4 af", cmd_q.size(),
                     cmd_q.size() > 2 ? cmd_q[2] : 8'h00);
        else npass++;
        ntotal++;
        if (wr_q.size() !== 1 || wr_q[0] !== {1'b0, 10'd37, 8'h3C})
            $display("FAIL col_cmds: got n=%0d entry %h want n=1 addr 37 data 3c", wr_q.size(),
                     wr_q.size() > 0 ? wr_q[0] : 19'd0);
        else npass++;
    endtask

    task automatic test_full_frame();
        int bad;
        int dones;
        logic [7:0] v;
        clear_capture();
        cs_begin();
        send_byte(8'hB0, 1'b0, 2);
        send_byte(8'h00, 1'b0, 2);
        send_byte(8'h10, 1'b0, 2);
        for (int i = 0; i < 1024; i++) begin
            v = 8'(i * 7 + 3);
            send_byte(v, 1'b1, 2);
        end
        send_byte(8'hEE, 1'b1, 2);
        tick(2);
        cs_end();
        ntotal++;
        if (wr_q.size() !== 1025) $display("FAIL frame_count: got %0d want 1025", wr_q.size());
        else npass++;
        if (wr_q.size() == 1025) begin
            bad = 0;
            dones = 0;
            for (int i = 0; i < 1024; i++) begin
                v = 8'(i * 7 + 3);
                if (wr_q[i][17:0] !== {10'(i), v}) bad++;
                if (wr_q[i][18]) dones++;
            end
            if (wr_q[1024][18]) dones++;
            ntotal++;
            if (bad !== 0) $display("FAIL frame_order: got %0d bad writes want 0", bad);
            else npass++;
            ntotal++;
            if (dones !== 1 || wr_q[1023][18] !== 1'b1)
                $display("FAIL frame_done: got %0d pulses (at 1023: %b) want 1 at 1023",
                         dones, wr_q[1023][18]);
            else npass++;
            ntotal++;
            if (wr_q[1024][17:0] !== {10'd0, 8'hEE})
                $display("FAIL frame_wrap: got addr %0d data %h want 0 ee",
                         wr_q[1024][17:8], wr_q[1024][7:0]);
            else npass++;
        end
        ntotal++;
        if (orphan_done !== 0) $display("FAIL frame_done_alone: got %0d want 0", orphan_done);
        else npass++;
    endtask

    task automatic test_abort();
        clear_capture();
        cs_begin();
        send_bits(8'h5F, 5, 1'b1, 3, 1'b0);
        tick(2);
        io_cs   = 1'b1;
        io_sclk = 1'b0;
        tick(8);
        ntotal++;
        if (err_cycles !== 1) $display("FAIL abort_err: got %0d cycles want 1", err_cycles);
        else npass++;
        ntotal++;
        if (wr_q.size() + cmd_q.size() !== 0)
            $display("FAIL abort_strobe: got %0d strobes want 0", wr_q.size() + cmd_q.size());
        else npass++;
        // Clock edges with cs deselected must be ignored
        send_bits(8'h00, 8, 1'b1, 3, 1'b0);
        io_sclk = 1'b0;
        tick(6);
        ntotal++;
        if (wr_q.size() + cmd_q.size() !== 0 || err_cycles !== 1)
            $display("FAIL cs_high_edges: got %0d strobes %0d err want 0 1",
                     wr_q.size() + cmd_q.size(), err_cycles);
        else npass++;
        cs_begin();
        send_byte(8'hFF, 1'b1, 3);
        tick(2);
        cs_end();
        ntotal++;
        if (wr_q.size() !== 1 || wr_q[0] !== {1'b0, 10'd1, 8'hFF})
            $display("FAIL after_abort: got n=%0d entry %h want addr 1 data ff", wr_q.size(),
                     wr_q.size() > 0 ? wr_q[0] : 19'd0);
        else npass++;
    endtask

    task automatic test_io_reset();
        clear_capture();
        cs_begin();
        send_byte(8'hB5, 1'b0, 3);
        send_byte(8'h0C, 1'b0, 3);
        send_byte(8'h13, 1'b0, 3);   // page 5, col 60
        send_bits(8'hC3, 4, 1'b1, 3, 1'b0);
        io_reset = 1'b0;
        tick(4);
        io_reset = 1'b1;
        tick(6);
        io_cs   = 1'b1;
        io_sclk = 1'b0;
        tick(6);
        ntotal++;
        if (wr_q.size() !== 0 || err_cycles !== 0)
            $display("FAIL io_reset_quiet: got %0d writes %0d err want 0 0", wr_q.size(), err_cycles);
        else npass++;
        cs_begin();
        send_byte(8'h77, 1'b1, 3);
        tick(2);
        cs_end();
        ntotal++;
        if (wr_q.size() !== 1 || wr_q[0] !== {1'b0, 10'd0, 8'h77})
            $display("FAIL io_reset_addr: got n=%0d entry %h want addr 0 data 77", wr_q.size(),
                     wr_q.size() > 0 ? wr_q[0] : 19'd0);
        else npass++;
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_b[64];
        int bad;
        clear_capture();
        cs_begin();
        send_byte(8'hB0, 1'b0, 2);
        send_byte(8'h00, 1'b0, 2);
        send_byte(8'h10, 1'b0, 2);
        for (int i = 0; i < 64; i++) begin
            exp_b[i] = 8'($urandom_range(0, 255));
            send_byte(exp_b[i], 1'b1, 2);
        end
        send_bits(8'h96, 8, 1'b1, 2, 1'b1);   // cs rises with the 8th edge
        tick(8);
        io_sclk = 1'b0;
        tick(4);
        ntotal++;
        if (wr_q.size() !== 65) $display("FAIL fast_count: got %0d want 65", wr_q.size());
        else npass++;
        if (wr_q.size() == 65) begin
            bad = 0;
            for (int i = 0; i < 64; i++)
                if (wr_q[i][17:0] !== {10'(i), exp_b[i]}) bad++;
            ntotal++;
            if (bad !== 0) $display("FAIL fast_bytes: got %0d bad want 0", bad);
            else npass++;
            ntotal++;
            if (wr_q[64][17:0] !== {10'd64, 8'h96})
                $display("FAIL cs_coincident: got addr %0d data %h want 64 96",
                         wr_q[64][17:8], wr_q[64][7:0]);
            else npass++;
        end
        ntotal++;
        if (err_cycles !== 0) $display("FAIL cs_coincident_err: got %0d want 0", err_cycles);
        else npass++;
    endtask

    task automatic test_rst_mid_byte();
        clear_capture();
        cs_begin();
        send_bits(8'hAA, 3, 1'b1, 3, 1'b0);
        rst = 1'b1;
        tick(2);
        io_cs   = 1'b1;
        io_sclk = 1'b0;
        tick(4);
        ntotal++;
        if (fb_addr !== 10'd0) $display("FAIL rst_fb_addr: got %0d want 0", fb_addr);
        else npass++;
        rst = 1'b0;
        tick(4);
        ntotal++;
        if (err_cycles !== 0 || wr_q.size() !== 0)
            $display("FAIL rst_mid_quiet: got %0d err %0d writes want 0 0", err_cycles, wr_q.size());
        else npass++;
        cs_begin();
        send_byte(8'h11, 1'b1, 3);
        tick(2);
        cs_end();
        ntotal++;
        if (wr_q.size() !== 1 || wr_q[0] !== {1'b0, 10'd0, 8'h11})
            $display("FAIL rst_mid_addr: got n=%0d entry %h want addr 0 data 11", wr_q.size(),
                     wr_q.size() > 0 ? wr_q[0] : 19'd0);
        else npass++;
    endtask

    initial begin
        test_reset();
        test_cmd_then_data();
        test_addr_cmds();
        test_full_frame();
        test_abort();
        test_io_reset();
        test_back_to_back();
        test_rst_mid_byte();
        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule
`default_nettype wire
